// File: rtl/lisnoc_router_input_route.sv
// Input-side routing stage of a lisnoc router port: decodes each packet's destination
// through a static one-hot table and holds that arbiter's request until the LAST flit.
module lisnoc_router_input_route #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_dest_width   = 5,
    parameter int num_dests       = 32,
    parameter int ports           = 5,
    parameter logic [num_dests*ports-1:0] lookup = '0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [flit_data_width+flit_type_width-1:0] in_flit_i,
    input  logic                                       in_valid_i,
    output logic                                       in_ready_o,
    output logic [flit_data_width+flit_type_width-1:0] out_flit_o,
    output logic [ports-1:0]                           out_request_o,
    input  logic [ports-1:0]                           out_read_i,
    output logic                                       err_o
);
    localparam int flit_width = flit_data_width + flit_type_width;

    typedef enum logic [1:0] {
        PAYLOAD = 2'b00,
        HEADER  = 2'b01,
        LAST    = 2'b10,
        SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP
    } state_e;

    state_e                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [flit_width-1:0]   out_flit_q, out_flit_d;
    logic [ports-1:0]        route_q, route_d;
    logic                    err_q, err_d;

    flit_type_e              flit_type;
    logic [ph_dest_width-1:0] dest;
    logic [ports-1:0]        entry;
    logic                    consume;
    logic                    accept;
    logic                    is_head;

    assign flit_type     = flit_type_e'(in_flit_i[flit_width-1 -: 2]);
    assign dest          = in_flit_i[flit_data_width-1 -: ph_dest_width];
    assign is_head       = (flit_type == HEADER) || (flit_type == SINGLE);

    assign out_request_o = route_q & {ports{out_valid_q}};
    assign consume       = |(out_request_o & out_read_i);
    assign in_ready_o    = ~out_valid_q | consume;
    assign accept        = in_valid_i & in_ready_o;

    assign out_flit_o    = out_flit_q;
    assign err_o         = err_q;

    // Destinations beyond the table fall through with an all-zero entry, i.e. a miss.
    always_comb begin
        entry = '0;
        for (int d = 0; d < num_dests; d++) begin
            if (dest == ph_dest_width'(d)) begin
                entry = lookup[d*ports +: ports];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q & ~consume;
        out_flit_d  = out_flit_q;
        route_d     = route_q;
        err_d       = 1'b0;

        if (accept) begin
            if (is_head) begin
                // A header outside IDLE means the previous packet lost its tail; resync here.
                if (state_q != IDLE) begin
                    err_d = 1'b1;
                end
                if (|entry) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = in_flit_i;
                    route_d     = entry;
                    state_d     = (flit_type == HEADER) ? ACTIVE : IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = (flit_type == HEADER) ? DROP : IDLE;
                end
            end else begin
                case (state_q)
                    ACTIVE: begin
                        out_valid_d = 1'b1;
                        out_flit_d  = in_flit_i;
                        if (flit_type == LAST) begin
                            state_d = IDLE;
                        end
                    end
                    DROP: begin
                        if (flit_type == LAST) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = (flit_type == PAYLOAD) ? DROP : IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            route_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            route_q     <= route_d;
            err_q       <= err_d;
        end
    end

endmodule
